vec_timer_seq: RTL and testbench

- Parametrised successor to the vector-duration timer in the vector generator datapath.
- Turns the 4-bit opcode/timer field, the global scale and the alphanumeric short-vector code into a beam-on interval of 2^(E+1) clocks.
- Adds an explicit start/busy/done handshake, hold (DMA stall) and abort.
- The exponent is clamped instead of wrapping.
- Sits between the opcode decoder/state sequencer and the X/Y integrator enables.

---
 rtl/vec_timer_seq_pkg.sv | 26 ++
 rtl/vec_timer_seq_if.sv | 29 ++
 rtl/vec_timer_len_dec.sv | 31 +++
 rtl/vec_timer_seq.sv | 116 +++++++++++
 tb/tb_vec_timer_seq.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_timer_seq_pkg.sv
// Shared types, constants and helpers for the vector-duration timer.
package vec_timer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // timer_val code that selects alphanumeric (short-vector) mode
   localparam logic [3:0] ALNUM_CODE_DEF = 4'hF;

   // Opcode bits that must both be set for scale_load to update the scale
   localparam int unsigned SCALE_BIT_HI = 3;
   localparam int unsigned SCALE_BIT_LO = 1;

   // Adder width: wide enough that sel + scale never overflows
   function automatic int unsigned sum_width(input int unsigned scale_w);
      return ((scale_w > 4) ? scale_w : 4) + 1;
   endfunction

   // Saturate the exponent instead of letting it wrap
   function automatic int unsigned exp_clamp(input int unsigned sum, input int unsigned emax);
      return (sum > emax) ? emax : sum;
   endfunction

endpackage

// File: rtl/vec_timer_seq_if.sv
// Instruction, handshake and status bundle between sequencer and vector timer.
interface vec_timer_seq_if #(
   parameter int unsigned COUNT_W = 12,
   parameter int unsigned SCALE_W = 4
);
   logic [3:0]         timer_val;
   logic               dvx_msb;
   logic               dvy_msb;
   logic [SCALE_W-1:0] scale_in;
   logic               scale_load;
   logic               start;
   logic               hold;
   logic               abort;
   logic               busy;
   logic               beam_on;
   logic               done;
   logic               alphanum;
   logic [COUNT_W-1:0] remaining;

   modport master (
      output timer_val, dvx_msb, dvy_msb, scale_in, scale_load, start, hold, abort,
      input  busy, beam_on, done, alphanum, remaining
   );

   modport slave (
      input  timer_val, dvx_msb, dvy_msb, scale_in, scale_load, start, hold, abort,
      output busy, beam_on, done, alphanum, remaining
   );
endinterface

// File: rtl/vec_timer_len_dec.sv
// Combinational exponent decode: selector mux, scale adder and clamp.
module vec_timer_len_dec
   import vec_timer_pkg::*;
#(
   parameter int unsigned COUNT_W    = 12,
   parameter int unsigned SCALE_W    = 4,
   parameter logic [3:0]  ALNUM_CODE = ALNUM_CODE_DEF
) (
   input  logic [3:0]                      timer_val,
   input  logic                            dvx_msb,
   input  logic                            dvy_msb,
   input  logic [SCALE_W-1:0]              scale_reg,
   output logic                            alphanum,
   output logic [sum_width(SCALE_W)-1:0]   exp_e
);

   localparam int unsigned SUM_W = sum_width(SCALE_W);
   localparam int unsigned EMAX  = COUNT_W - 3;

   logic [3:0]       sel;
   logic [SUM_W-1:0] sum;

   // Short vectors derive their length code from the delta MSBs
   always_comb begin
      alphanum = (timer_val == ALNUM_CODE);
      sel      = alphanum ? {1'b0, dvx_msb, ~dvx_msb, dvy_msb} : timer_val;
      sum      = SUM_W'(sel) + SUM_W'(scale_reg);
      exp_e    = SUM_W'(exp_clamp(32'(sum), EMAX));
   end

endmodule

// File: rtl/vec_timer_seq.sv
// Vector-duration timer: start/busy/done handshake with hold and abort.
module vec_timer_seq
   import vec_timer_pkg::*;
#(
   parameter int unsigned COUNT_W    = 12,
   parameter int unsigned SCALE_W    = 4,
   parameter logic [3:0]  ALNUM_CODE = ALNUM_CODE_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   vec_timer_seq_if.slave  bus
);

   localparam int unsigned E_W = sum_width(SCALE_W);

   state_t             state_q, state_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [E_W-1:0]     exp_q, exp_d;
   logic [SCALE_W-1:0] scale_q, scale_d;
   logic               done_q, done_d;
   logic [E_W-1:0]     exp_e;
   logic [COUNT_W-1:0] load_cnt;
   logic [COUNT_W-1:0] max_cnt;

   vec_timer_len_dec #(
      .COUNT_W    (COUNT_W),
      .SCALE_W    (SCALE_W),
      .ALNUM_CODE (ALNUM_CODE)
   ) u_len_dec (
      .timer_val (bus.timer_val),
      .dvx_msb   (bus.dvx_msb),
      .dvy_msb   (bus.dvy_msb),
      .scale_reg (scale_q),
      .alphanum  (bus.alphanum),
      .exp_e     (exp_e)
   );

   // Duration minus one for the new vector and for the vector in flight
   always_comb begin
      load_cnt = (COUNT_W'(1) << (exp_e + E_W'(1))) - COUNT_W'(1);
      max_cnt  = (COUNT_W'(1) << (exp_q + E_W'(1))) - COUNT_W'(1);
   end

   // State, counter, exponent, scale and done registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         count_q <= '0;
         exp_q   <= '0;
         scale_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         exp_q   <= exp_d;
         scale_q <= scale_d;
         done_q  <= done_d;
      end
   end

   // The running count can never exceed the length latched at start
   always_ff @(posedge clk) begin
      if (reset_n && (state_q == RUN)) begin
         assert (count_q <= max_cnt);
      end
   end

   // Next-state logic: abort beats hold, hold beats completion
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      exp_d   = exp_q;
      scale_d = scale_q;
      done_d  = 1'b0;

      if (bus.scale_load && bus.timer_val[SCALE_BIT_HI] && bus.timer_val[SCALE_BIT_LO]) begin
         scale_d = bus.scale_in;
      end

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               exp_d   = exp_e;
               count_d = load_cnt;
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.abort) begin
               count_d = '0;
               state_d = IDLE;
            end else if (bus.hold) begin
               count_d = count_q;
            end else if (count_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               count_d = count_q - COUNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   // Status outputs straight from registers
   always_comb begin
      bus.busy      = (state_q == RUN);
      bus.beam_on   = (state_q == RUN);
      bus.done      = done_q;
      bus.remaining = (state_q == RUN) ? count_q : '0;
   end

endmodule

// File: tb/tb_vec_timer_seq.sv
// Scoreboard bench for vec_timer_seq against a per-vector duration model.
module tb_vec_timer_seq;

   localparam int unsigned COUNT_W = 12;
   localparam int unsigned SCALE_W = 4;
   localparam int          EMAX    = COUNT_W - 3;

   typedef struct {
      int len;   // cycles with busy high
      bit dn;    // done pulse expected after the vector
      int rem0;  // remaining in the first busy cycle
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_errs   = 0;
   int   scale_m  = 0;
   exp_t exp_q[$];

   vec_timer_seq_if #(.COUNT_W(COUNT_W), .SCALE_W(SCALE_W)) bus ();

   vec_timer_seq #(.COUNT_W(COUNT_W), .SCALE_W(SCALE_W), .ALNUM_CODE(4'hF)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint expv);
      n_checks++;
      if (act != expv) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: measures each busy burst and compares it with the queued expectation
   bit prev_busy = 1'b0;
   int blen      = 0;
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_busy = 1'b0;
         blen      = 0;
         exp_q     = {};
      end else begin
         chk("beam_on_eq_busy", bus.beam_on, bus.busy);
         if (bus.busy) begin
            if (!prev_busy) begin
               blen = 1;
               if (exp_q.size() == 0) chk("unexpected_vector", 1, 0);
               else chk("remaining_first", bus.remaining, exp_q[0].rem0);
            end else begin
               blen++;
            end
         end else if (prev_busy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_end", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("busy_len", blen, e.len);
               chk("done_pulse", bus.done, e.dn);
            end
         end else begin
            chk("idle_done_low", bus.done, 0);
            chk("idle_remaining", bus.remaining, 0);
         end
         prev_busy = bus.busy;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 3000) begin
         tick();
         n++;
      end
      if (bus.busy) begin
         chk("idle_timeout", 1, 0);
      end
   endtask

   task automatic load_scale(input logic [3:0] tv, input logic [3:0] sc);
      bus.timer_val  = tv;
      bus.scale_in   = sc;
      bus.scale_load = 1'b1;
      tick();
      bus.scale_load = 1'b0;
      if (tv[3] && tv[1]) scale_m = int'(sc);
   endtask

   // Reference length: D work cycles, held cycles add one each, abort cuts short
   task automatic do_vec(input logic [3:0] tv, input logic dx, input logic dy,
                         input int hold_at, input int hold_len, input int abort_at,
                         input bit mid_start);
      int   sel, e, d, work, len;
      bit   dn;
      exp_t it;
      if (tv == 4'hF) sel = (dx ? 4 : 2) + (dy ? 1 : 0);
      else            sel = int'(tv);
      e = sel + scale_m;
      if (e > EMAX) e = EMAX;
      d    = 1 << (e + 1);
      work = d;
      len  = 0;
      dn   = 1'b0;
      for (int i = 1; i < 10000; i++) begin
         if (i == abort_at) begin
            len = i;
            dn  = 1'b0;
            break;
         end
         if (i >= hold_at && i < hold_at + hold_len) continue;
         work--;
         if (work == 0) begin
            len = i;
            dn  = 1'b1;
            break;
         end
      end
      it.len  = len;
      it.dn   = dn;
      it.rem0 = d - 1;
      exp_q.push_back(it);

      bus.timer_val = tv;
      bus.dvx_msb   = dx;
      bus.dvy_msb   = dy;
      bus.start     = 1'b1;
      #1;
      chk("alphanum", bus.alphanum, (tv == 4'hF));
      tick();
      bus.start     = 1'b0;
      bus.timer_val = 4'($urandom);
      bus.dvx_msb   = 1'($urandom);
      bus.dvy_msb   = 1'($urandom);
      for (int i = 1; i <= len; i++) begin
         bus.hold  = (i >= hold_at && i < hold_at + hold_len);
         bus.abort = (i == abort_at);
         bus.start = (mid_start && i == 5);
         tick();
      end
      bus.hold  = 1'b0;
      bus.abort = 1'b0;
      bus.start = 1'b0;
      tick();
   endtask

   initial begin
      exp_t it;
      bus.timer_val  = 4'h0;
      bus.dvx_msb    = 1'b0;
      bus.dvy_msb    = 1'b0;
      bus.scale_in   = '0;
      bus.scale_load = 1'b0;
      bus.start      = 1'b0;
      bus.hold       = 1'b0;
      bus.abort      = 1'b0;
      reset_n        = 1'b0;
      #12;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_remaining", bus.remaining, 0);
      tick();
      reset_n = 1'b1;
      tick();

      // Basic and alphanumeric lengths
      do_vec(4'h3, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      do_vec(4'hF, 1'b1, 1'b0, 0, 0, 0, 1'b0);
      do_vec(4'hF, 1'b0, 1'b1, 0, 0, 0, 1'b0);

      // Scale latch, clamp, and a non-latching scale_load
      load_scale(4'hA, 4'h2);
      do_vec(4'h9, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      load_scale(4'h9, 4'h5);
      do_vec(4'h0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      load_scale(4'hA, 4'h0);

      // Shortest vector with hold on the first and on the last cycle
      do_vec(4'h0, 1'b0, 1'b0, 1, 1, 0, 1'b0);
      do_vec(4'h0, 1'b0, 1'b0, 2, 3, 0, 1'b0);

      // Start pulsed mid-vector is ignored; abort in cycle 5
      do_vec(4'h3, 1'b0, 1'b0, 0, 0, 0, 1'b1);
      do_vec(4'h3, 1'b0, 1'b0, 0, 0, 5, 1'b0);

      // Start held high: 16 on / 1 off, three vectors
      it.len = 16; it.dn = 1'b1; it.rem0 = 15;
      repeat (3) exp_q.push_back(it);
      bus.timer_val = 4'h3;
      bus.start     = 1'b1;
      repeat (35) @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (18) tick();
      wait_idle();

      // Reset in the middle of a vector with a nonzero scale
      load_scale(4'hB, 4'h1);
      it.len = 0; it.dn = 1'b0; it.rem0 = 31;
      exp_q.push_back(it);
      bus.timer_val = 4'h3;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      reset_n = 1'b0;
      #1;
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_remaining", bus.remaining, 0);
      chk("rst_mid_done", bus.done, 0);
      tick();
      reset_n = 1'b1;
      scale_m = 0;
      repeat (3) tick();
      do_vec(4'h3, 1'b0, 1'b0, 0, 0, 0, 1'b0);

      // Randomized vectors with scale updates, holds and aborts
      for (int n = 0; n < 20; n++) begin
         logic [3:0] tv;
         int ha, hl, ab;
         if ($urandom_range(0, 2) == 0) load_scale(4'($urandom), 4'($urandom_range(0, 3)));
         tv = 4'($urandom);
         ha = $urandom_range(1, 20);
         hl = $urandom_range(0, 3);
         ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 20) : 0;
         wait_idle();
         do_vec(tv, 1'($urandom), 1'($urandom), ha, hl, ab, 1'($urandom));
      end

      wait_idle();
      repeat (3) tick();
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
